// File: rtl/aes_pkg.sv
// Shared constants, state type and helpers for the AES round scheduler and
// its round-robin arbiter.
package aes_pkg;

  localparam int RND_W  = 4;
  localparam int KIDX_W = 4;

  localparam logic [1:0] MODE_INV = 2'b00;
  localparam logic [1:0] MODE_128 = 2'b01;
  localparam logic [1:0] MODE_192 = 2'b10;
  localparam logic [1:0] MODE_256 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Round count for a key size; the invalid encoding yields zero rounds.
  function automatic logic [RND_W-1:0] nr_of(input logic [1:0] mode);
    logic [RND_W-1:0] nr_v;
    case (mode)
      MODE_128: nr_v = 4'd10;
      MODE_192: nr_v = 4'd12;
      MODE_256: nr_v = 4'd14;
      default:  nr_v = 4'd0;
    endcase
    return nr_v;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after the
// last-granted index, wrapping; the pointer moves only on advance.
module aes_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);

  logic [IDW-1:0]  last_r;
  logic [NREQ-1:0] hi_req_s;
  logic [IDW-1:0]  hi_id_s;
  logic [IDW-1:0]  lo_id_s;

  // Lowest request above the pointer wins; otherwise wrap to the lowest request.
  always_comb begin
    hi_req_s = '0;
    hi_id_s  = '0;
    lo_id_s  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      hi_req_s[i] = req[i] & (IDW'(i) > last_r);
      lo_id_s     = req[i]      ? IDW'(i) : lo_id_s;
      hi_id_s     = hi_req_s[i] ? IDW'(i) : hi_id_s;
    end
  end

  assign id    = (|hi_req_s) ? hi_id_s : lo_id_s;
  assign grant = (enable && (|req)) ? ({{(NREQ-1){1'b0}}, 1'b1} << id) : '0;

  // Last-granted pointer; the reset value puts requester 0 first in line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r <= IDW'(NREQ - 1);
    end else if (advance) begin
      last_r <= id;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one iterative AES round datapath among NREQ requesters: round-robin
// accept, LOAD, nr ROUND cycles, DONE handshake. Option: AES_SCHED_ABORT_EN.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_mode,
  input  logic [NREQ-1:0]     req_dir,
  output logic [NREQ-1:0]     req_ready,
  output logic                dp_load,
  output logic                dp_round_en,
  output logic [RND_W-1:0]    dp_round,
  output logic [KIDX_W-1:0]   dp_key_idx,
  output logic                dp_last,
  output logic                dp_dir,
  output logic [1:0]          dp_mode,
  output logic                done_valid,
  output logic [IDW-1:0]      done_id,
  input  logic                done_ready,
  output logic                busy,
`ifdef AES_SCHED_ABORT_EN
  input  logic                abort,
  output logic                aborted,
`endif
  output logic                err_mode
);

  sched_state_e     state_r, state_nx;
  logic [RND_W-1:0] round_r, round_nx;
  logic [1:0]       mode_r, mode_nx, sel_mode_s;
  logic             dir_r, dir_nx, sel_dir_s;
  logic [IDW-1:0]   id_r, id_nx, arb_id_s;
  logic [NREQ-1:0]  arb_grant_s;
  logic             armed_r;
  logic             arb_en_s, xfer_s, err_nx, abort_s, abort_hit_s;
  logic [RND_W-1:0] nr_r_s, nr_nx_s;

  logic              dp_load_nx, dp_round_en_nx, dp_last_nx;
  logic [RND_W-1:0]  dp_round_nx;
  logic [KIDX_W-1:0] dp_key_idx_nx;

`ifdef AES_SCHED_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // armed_r keeps req_ready low from reset until the first edge after release.
  assign arb_en_s    = armed_r && (state_r == IDLE);
  assign xfer_s      = |(arb_grant_s & req_valid);
  assign abort_hit_s = abort_s && ((state_r == LOAD) || (state_r == ROUND));
  assign nr_r_s      = nr_of(mode_r);
  assign nr_nx_s     = nr_of(mode_nx);
  assign req_ready   = arb_grant_s;

  aes_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .enable  (arb_en_s),
    .advance (xfer_s),
    .grant   (arb_grant_s),
    .id      (arb_id_s)
  );

  // Pick the granted requester's mode and direction.
  always_comb begin
    sel_mode_s = MODE_INV;
    sel_dir_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_mode_s = arb_grant_s[i] ? req_mode[2*i +: 2] : sel_mode_s;
      sel_dir_s  = arb_grant_s[i] ? req_dir[i]         : sel_dir_s;
    end
  end

  // Next-state logic and job descriptor latching.
  always_comb begin
    state_nx = state_r;
    round_nx = round_r;
    mode_nx  = mode_r;
    dir_nx   = dir_r;
    id_nx    = id_r;
    err_nx   = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          id_nx    = arb_id_s;
          mode_nx  = sel_mode_s;
          dir_nx   = sel_dir_s;
          round_nx = 4'd0;
          if (sel_mode_s == MODE_INV) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = LOAD;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        if (abort_hit_s) begin
          state_nx = IDLE;
          round_nx = 4'd0;
        end else begin
          state_nx = ROUND;
          round_nx = 4'd1;
        end
      end
      ROUND: begin
        if (abort_hit_s) begin
          state_nx = IDLE;
          round_nx = 4'd0;
        end else if (round_r >= nr_r_s) begin
          state_nx = DONE;
          round_nx = 4'd0;
        end else begin
          state_nx = ROUND;
          round_nx = round_r + 4'd1;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
        round_nx = 4'd0;
      end
    endcase
  end

  // Datapath controls for the coming cycle; decryption walks keys backwards.
  always_comb begin
    dp_load_nx     = 1'b0;
    dp_round_en_nx = 1'b0;
    dp_round_nx    = 4'd0;
    dp_key_idx_nx  = 4'd0;
    dp_last_nx     = 1'b0;
    case (state_nx)
      LOAD: begin
        dp_load_nx    = 1'b1;
        dp_key_idx_nx = dir_nx ? nr_nx_s : 4'd0;
      end
      ROUND: begin
        dp_round_en_nx = 1'b1;
        dp_round_nx    = round_nx;
        dp_key_idx_nx  = dir_nx ? (nr_nx_s - round_nx) : round_nx;
        dp_last_nx     = (round_nx == nr_nx_s);
      end
      default: begin
        dp_load_nx = 1'b0;
      end
    endcase
  end

  // Control state and the latched job descriptor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      round_r <= 4'd0;
      mode_r  <= MODE_INV;
      dir_r   <= 1'b0;
      id_r    <= '0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      round_r <= round_nx;
      mode_r  <= mode_nx;
      dir_r   <= dir_nx;
      id_r    <= id_nx;
      armed_r <= 1'b1;
    end
  end

  // Registered datapath, handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_load     <= 1'b0;
      dp_round_en <= 1'b0;
      dp_round    <= 4'd0;
      dp_key_idx  <= 4'd0;
      dp_last     <= 1'b0;
      dp_dir      <= 1'b0;
      dp_mode     <= MODE_INV;
      done_valid  <= 1'b0;
      done_id     <= '0;
      busy        <= 1'b0;
      err_mode    <= 1'b0;
    end else begin
      dp_load     <= dp_load_nx;
      dp_round_en <= dp_round_en_nx;
      dp_round    <= dp_round_nx;
      dp_key_idx  <= dp_key_idx_nx;
      dp_last     <= dp_last_nx;
      dp_dir      <= (state_nx != IDLE) ? dir_nx : 1'b0;
      dp_mode     <= (state_nx != IDLE) ? mode_nx : MODE_INV;
      done_valid  <= (state_nx == DONE);
      done_id     <= (state_nx == DONE) ? id_nx : '0;
      busy        <= (state_nx != IDLE);
      err_mode    <= err_nx;
    end
  end

`ifdef AES_SCHED_ABORT_EN
  // One-cycle pulse when a running job is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit_s;
    end
  end
`else
`endif

endmodule
